// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state type and default sizing for the programmable clock divider
package clk_div_pkg;

  // Divider operating state; PEND is RUN with a ratio request waiting for the period boundary
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_STOP = 2'd3
  } div_state_t;

  localparam int CLK_DIV_CNT_W   = 8;
  localparam int CLK_DIV_DEF_DIV = 1;

endpackage

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable 50%-duty clock divider with glitch-free ratio load/ack handshake
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CLK_DIV_CNT_W,
  parameter int DEF_DIV = CLK_DIV_DEF_DIV
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_ack,
  output logic             div_err,
  output logic [CNT_W-1:0] div_cur,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  div_state_t       state;
  div_state_t       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] pend_n;
  logic [CNT_W-1:0] div_cur_n;
  logic             clk_out_n;
  logic             tick_n;
  logic             div_busy_n;
  logic             div_ack_n;
  logic             div_err_n;

  logic             req_ok;
  logic             req_zero;
  logic             expire;
  logic             draining;

  // A request is only looked at while nothing is pending; a zero ratio is rejected
  assign req_ok   = div_load && !div_busy && (div_in != '0);
  assign req_zero = div_load && !div_busy && (div_in == '0);
  // Last cycle of the current half period
  assign expire   = (cnt == (div_cur - ONE));
  // Run request withdrawn and the current phase ends now: the divider parks low this edge
  assign draining = !en && expire;

  // Register every output and all control state
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pend     <= '0;
      div_cur  <= DEF;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      div_busy <= 1'b0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pend     <= pend_n;
      div_cur  <= div_cur_n;
      clk_out  <= clk_out_n;
      tick     <= tick_n;
      div_busy <= div_busy_n;
      div_ack  <= div_ack_n;
      div_err  <= div_err_n;
    end
  end

  // Next state, half-period counting, toggle and ratio handshake
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pend_n     = pend;
    div_cur_n  = div_cur;
    clk_out_n  = clk_out;
    tick_n     = 1'b0;
    div_busy_n = div_busy;
    div_ack_n  = 1'b0;
    div_err_n  = req_zero;

    if (state == ST_IDLE) begin
      cnt_n     = '0;
      clk_out_n = 1'b0;
      // Stopped: a new ratio can be applied straight away
      if (req_ok) begin
        div_cur_n = div_in;
        div_ack_n = 1'b1;
      end
      if (en) begin
        state_n   = ST_RUN;
        clk_out_n = 1'b1;
        tick_n    = 1'b1;
      end
    end else begin
      cnt_n = expire ? '0 : cnt + ONE;

      if (expire && clk_out) begin
        // Period boundary (1->0): the only point where the ratio may change
        clk_out_n = 1'b0;
        tick_n    = 1'b1;
        if (div_busy) begin
          div_cur_n  = pend;
          div_ack_n  = 1'b1;
          div_busy_n = 1'b0;
        end
      end else if (expire && en) begin
        // End of low phase; suppressed while stopping so clk_out stays parked low
        clk_out_n = 1'b1;
        tick_n    = 1'b1;
      end

      if (req_ok) begin
        if (draining) begin
          // No later boundary will come, so apply as if already idle
          div_cur_n = div_in;
          div_ack_n = 1'b1;
        end else begin
          pend_n     = div_in;
          div_busy_n = 1'b1;
        end
      end

      if (!en) begin
        state_n = expire ? ST_IDLE : ST_STOP;
      end else begin
        state_n = div_busy_n ? ST_PEND : ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - self-checking bench for clk_div_prog with a phase-countdown reference model
module tb_clk_div_prog;

  logic       clkin;
  logic       rst;
  logic       en;
  logic [7:0] div_in;
  logic       div_load;
  logic       div_busy;
  logic       div_ack;
  logic       div_err;
  logic [7:0] div_cur;
  logic       clk_out;
  logic       tick;

  int   total;
  int   bad;
  logic mon_on;

  clk_div_prog dut (
    .clkin    (clkin),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .div_busy (div_busy),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .div_cur  (div_cur),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Reference: a running divider is a level plus the number of cycles left in that level
  typedef struct packed {
    logic on;
    logic lvl;
    logic busy;
    logic tick;
    logic ack;
    logic err;
    int   left;
    int   n;
    int   pend;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_reset();
    mstate_t s;
    s   = '0;
    s.n = 1;
    return s;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic e, input logic ld,
                                         input logic [7:0] din);
    mstate_t r;
    logic    take;
    r      = s;
    r.tick = 1'b0;
    r.ack  = 1'b0;
    take   = ld && !s.busy && (din != 8'd0);
    r.err  = ld && !s.busy && (din == 8'd0);
    if (!s.on) begin
      if (take) begin
        r.n   = int'(din);
        r.ack = 1'b1;
      end
      if (e) begin
        r.on   = 1'b1;
        r.lvl  = 1'b1;
        r.tick = 1'b1;
        r.left = r.n;
      end
    end else begin
      r.left = s.left - 1;
      if (r.left == 0) begin
        if (s.lvl) begin
          r.lvl  = 1'b0;
          r.tick = 1'b1;
          if (s.busy) begin
            r.n    = s.pend;
            r.busy = 1'b0;
            r.ack  = 1'b1;
          end
        end else if (e) begin
          r.lvl  = 1'b1;
          r.tick = 1'b1;
        end
        r.left = r.n;
        if (!e) r.on = 1'b0;
      end
      if (take) begin
        if (!r.on) begin
          r.n   = int'(din);
          r.ack = 1'b1;
        end else begin
          r.pend = int'(din);
          r.busy = 1'b1;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clkin or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, en, div_load, div_in);
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Every cycle: all outputs against the model
  always @(negedge clkin) begin
    if (mon_on) begin
      check("mon_clk_out",  int'(clk_out),  int'(m.lvl));
      check("mon_tick",     int'(tick),     int'(m.tick));
      check("mon_div_busy", int'(div_busy), int'(m.busy));
      check("mon_div_ack",  int'(div_ack),  int'(m.ack));
      check("mon_div_err",  int'(div_err),  int'(m.err));
      check("mon_div_cur",  int'(div_cur),  m.n);
    end
  end

  // Observe clk_out on n successive cycles against a literal bit pattern (MSB first)
  task automatic seq_check(input string nm, input int n, input logic [31:0] pat);
    for (int i = 0; i < n; i++) begin
      @(negedge clkin);
      check(nm, int'(clk_out), int'(pat[n-1-i]));
    end
  endtask

  task automatic wait_ack(input string nm, input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clkin);
      seen = div_ack;
    end
    check(nm, int'(seen), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ack_seen;
    total    = 0;
    bad      = 0;
    mon_on   = 1'b0;
    rst      = 1'b1;
    en       = 1'b0;
    div_load = 1'b0;
    div_in   = 8'd0;
    repeat (2) @(negedge clkin);
    mon_on = 1'b1;
    rst    = 1'b0;
    @(negedge clkin);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_div_cur", int'(div_cur), 1);
    check("rst_busy",    int'(div_busy), 0);

    // Default ratio 1: toggles every cycle with a tick each cycle
    en = 1'b1;
    seq_check("t1_clk", 4, 32'b1010);
    check("t1_tick", int'(tick), 1);
    en = 1'b0;
    @(negedge clkin);
    check("t1_park_clk",  int'(clk_out), 0);
    check("t1_park_tick", int'(tick), 0);

    // Load 3 while idle, then run
    div_in   = 8'd3;
    div_load = 1'b1;
    @(negedge clkin);
    check("t2_ack",     int'(div_ack), 1);
    check("t2_div_cur", int'(div_cur), 3);
    check("t2_busy",    int'(div_busy), 0);
    div_load = 1'b0;
    en       = 1'b1;
    seq_check("t2_clk", 7, 32'b1110001);

    // Load 5 in first high cycle; second load while busy is ignored
    div_in   = 8'd5;
    div_load = 1'b1;
    @(negedge clkin);
    check("t3_busy", int'(div_busy), 1);
    div_in = 8'd7;
    @(negedge clkin);
    check("t3_busy_hold", int'(div_busy), 1);
    check("t3_old_div",   int'(div_cur), 3);
    div_load = 1'b0;
    @(negedge clkin);
    check("t3_ack",      int'(div_ack), 1);
    check("t3_div_cur",  int'(div_cur), 5);
    check("t3_clk_fall", int'(clk_out), 0);
    check("t3_busy_clr", int'(div_busy), 0);
    seq_check("t3_clk", 10, 32'b0000111110);
    check("t3_div_kept", int'(div_cur), 5);

    // Zero ratio request
    div_in   = 8'd0;
    div_load = 1'b1;
    @(negedge clkin);
    check("t4_err",     int'(div_err), 1);
    check("t4_div_cur", int'(div_cur), 5);
    check("t4_busy",    int'(div_busy), 0);
    div_load = 1'b0;
    @(negedge clkin);
    check("t4_err_pulse", int'(div_err), 0);

    // Ratio 4, then stop in second high cycle
    div_in   = 8'd4;
    div_load = 1'b1;
    @(negedge clkin);
    check("t5_busy", int'(div_busy), 1);
    div_load = 1'b0;
    wait_ack("t5_ack_seen", 16);
    check("t5_div_cur", int'(div_cur), 4);
    check("t5_clk_low", int'(clk_out), 0);
    seq_check("t5_low", 4, 32'b0001);
    @(negedge clkin);
    check("t5_high2", int'(clk_out), 1);
    en = 1'b0;
    seq_check("t5_stop", 6, 32'b110000);

    // Restart, drop en briefly, re-raise during the drain: waveform continues without a gap
    en = 1'b1;
    seq_check("t5_start", 2, 32'b11);
    en = 1'b0;
    @(negedge clkin);
    check("t5_stop_high", int'(clk_out), 1);
    en = 1'b1;
    seq_check("t5_resume", 6, 32'b100001);

    // Reset while a request is pending mid high phase
    div_in   = 8'd2;
    div_load = 1'b1;
    @(negedge clkin);
    check("t6_busy", int'(div_busy), 1);
    div_load = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("t6_rst_clk",  int'(clk_out), 0);
    check("t6_rst_div",  int'(div_cur), 1);
    check("t6_rst_busy", int'(div_busy), 0);
    repeat (2) @(negedge clkin);
    rst      = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clkin);
      check("t6_clk", int'(clk_out), (i % 2 == 0) ? 1 : 0);
      ack_seen = ack_seen | div_ack;
    end
    check("t6_no_ack", int'(ack_seen), 0);

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
